// File: rtl/sram_arb2.sv
// Two-master round-robin arbiter and cycle sequencer for a 32Kx8 async SRAM.
// Ports: clk/rst (async, active-low); per master m0_*/m1_* req/we/addr/wdata in,
//        ack/rdata out; SRAM pins cs_n/we_n/oe_n/addr/data (inout); busy out.
`timescale 1ns/1ps
module sram_arb2 #(
    parameter int AW       = 15,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          sram_cs_n,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_data,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_TURN
    } state_t;

    localparam int CMAX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] TURN_LD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_gnt;
    logic          r_last;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_cs_n;
    logic          r_we_n;
    logic          r_oe_n;
    logic          r_drv;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rd0;
    logic [DW-1:0] r_rd1;
    logic          r_busy;

    state_t        w_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_take;
    logic          w_any;
    logic          w_sel;
    logic          w_gnt;
    logic          w_we;
    logic          w_act;

    always_comb begin
        w_any     = m0_req | m1_req;
        // r_last=1 means m1 was served last, so m0 wins a tie
        w_sel     = (m0_req & m1_req) ? ~r_last : ~m0_req;
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_take    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_take = 1'b1;
                    w_nxt  = S_SETUP;
                end
            end
            S_SETUP: begin
                w_nxt     = S_STROBE;
                w_cnt_nxt = WAIT_LD;
            end
            S_STROBE: begin
                if (r_cnt == '0) begin
                    w_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (TURN_CYC == 0) begin
                    w_nxt = S_IDLE;
                end else begin
                    w_nxt     = S_TURN;
                    w_cnt_nxt = TURN_LD;
                end
            end
            S_TURN: begin
                // last turn clock doubles as the idle sample slot so that
                // queued requests follow with only the turnaround gap
                if (r_cnt == '0) begin
                    if (w_any) begin
                        w_take = 1'b1;
                        w_nxt  = S_SETUP;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        w_gnt = w_take ? w_sel : r_gnt;
        w_we  = w_take ? (w_sel ? m1_we : m0_we) : r_we;
        w_act = (w_nxt == S_SETUP) || (w_nxt == S_STROBE) ||
                (w_nxt == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cs_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_drv   <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt;
            r_we    <= w_we;
            if (w_take) begin
                r_last  <= w_sel;
                r_addr  <= w_sel ? m1_addr : m0_addr;
                r_wdata <= w_sel ? m1_wdata : m0_wdata;
            end
            r_cs_n <= ~w_act;
            r_we_n <= ~((w_nxt == S_STROBE) && w_we);
            r_oe_n <= ~((w_nxt == S_STROBE) && !w_we);
            r_drv  <= w_act && w_we;
            r_ack0 <= (w_nxt == S_HOLD) && !w_gnt;
            r_ack1 <= (w_nxt == S_HOLD) && w_gnt;
            r_busy <= (w_nxt != S_IDLE);
            // capture at the edge ending the last strobe clock
            if ((r_state == S_STROBE) && (r_cnt == '0) && !r_we) begin
                if (r_gnt) begin
                    r_rd1 <= sram_data;
                end else begin
                    r_rd0 <= sram_data;
                end
            end
        end
    end

    assign sram_data = r_drv ? r_wdata : {DW{1'bz}};
    assign sram_cs_n = r_cs_n;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = r_oe_n;
    assign sram_addr = r_addr;
    assign m0_ack    = r_ack0;
    assign m1_ack    = r_ack1;
    assign m0_rdata  = r_rd0;
    assign m1_rdata  = r_rd1;
    assign busy      = r_busy;

endmodule
